// File: rtl/z80_bus_target_if.sv
// Z80 bus target interface: CPU bus pins plus the fabric request/ack channel.
// The slave modport is the bus target; the master modport is the CPU and fabric side.
interface z80_bus_target_if;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        wait_n;
  logic        int_n;
  logic        f_req;
  logic        f_io;
  logic        f_wr;
  logic [15:0] f_addr;
  logic [7:0]  f_wdata;
  logic        f_ack;
  logic [7:0]  f_rdata;
  logic        irq;
  logic [7:0]  irq_vector;
  logic        timeout;

  modport slave (
    input  bus_addr, bus_din, mreq_n, iorq_n, rd_n, wr_n,
    input  f_ack, f_rdata, irq, irq_vector,
    output bus_dout, bus_doe, wait_n, int_n,
    output f_req, f_io, f_wr, f_addr, f_wdata, timeout
  );

  modport master (
    output bus_addr, bus_din, mreq_n, iorq_n, rd_n, wr_n,
    output f_ack, f_rdata, irq, irq_vector,
    input  bus_dout, bus_doe, wait_n, int_n,
    input  f_req, f_io, f_wr, f_addr, f_wdata, timeout
  );
endinterface

// File: rtl/z80_bus_target.sv
// Z80 bus target: decodes CPU memory/IO/INTA cycles, forwards reads and writes
// to the fabric over a req/ack handshake, stalls the CPU with wait_n until the
// fabric answers (or a timeout forces completion), and drives read data/vectors.
module z80_bus_target #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset,
  z80_bus_target_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, INTA} state_t;

  state_t      state_q, state_d;
  logic [7:0]  counter_q, counter_d;
  logic [7:0]  busDout_q, busDout_d;
  logic        busDoe_q, busDoe_d;
  logic        waitN_q, waitN_d;
  logic        intN_q;
  logic        fReq_q, fReq_d;
  logic        fIo_q, fIo_d;
  logic        fWr_q, fWr_d;
  logic [15:0] fAddr_q, fAddr_d;
  logic [7:0]  fWdata_q, fWdata_d;
  logic        timeout_q, timeout_d;

  logic [SYNC_STAGES-1:0] mreqSync_q, iorqSync_q, rdSync_q, wrSync_q;
  logic mreqS, iorqS, rdS, wrS;
  logic [7:0] cntNext;
  logic accessCycle, intaCycle, reqStrobeHigh;

  // Strobe synchronisers; idle-high so reset looks like "no cycle in progress"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mreqSync_q <= '1;
      iorqSync_q <= '1;
      rdSync_q   <= '1;
      wrSync_q   <= '1;
    end else begin
      mreqSync_q <= {mreqSync_q[SYNC_STAGES-2:0], bus.mreq_n};
      iorqSync_q <= {iorqSync_q[SYNC_STAGES-2:0], bus.iorq_n};
      rdSync_q   <= {rdSync_q[SYNC_STAGES-2:0], bus.rd_n};
      wrSync_q   <= {wrSync_q[SYNC_STAGES-2:0], bus.wr_n};
    end
  end

  assign mreqS = mreqSync_q[SYNC_STAGES-1];
  assign iorqS = iorqSync_q[SYNC_STAGES-1];
  assign rdS   = rdSync_q[SYNC_STAGES-1];
  assign wrS   = wrSync_q[SYNC_STAGES-1];

  // Cycle decode: a read/write needs exactly one of mreq/iorq low; both low is
  // not a legal Z80 cycle and is ignored; iorq alone with no strobe is INTA
  assign accessCycle = (mreqS ^ iorqS) && (!rdS || !wrS);
  assign intaCycle   = mreqS && !iorqS && rdS && wrS;
  assign cntNext     = counter_q + 8'd1;

  // HOLD exits only once the strobe that started this cycle has gone away
  assign reqStrobeHigh = fIo_q ? iorqS : mreqS;

  // Next-state and output logic for the cycle FSM
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    busDout_d = busDout_q;
    busDoe_d  = busDoe_q;
    waitN_d   = waitN_q;
    fReq_d    = fReq_q;
    fIo_d     = fIo_q;
    fWr_d     = fWr_q;
    fAddr_d   = fAddr_q;
    fWdata_d  = fWdata_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accessCycle) begin
          fAddr_d   = bus.bus_addr;
          fWdata_d  = bus.bus_din;
          fIo_d     = mreqS;
          fWr_d     = rdS;
          fReq_d    = 1'b1;
          waitN_d   = 1'b0;
          counter_d = 8'd0;
          state_d   = REQ;
        end else if (intaCycle) begin
          busDout_d = bus.irq_vector;
          busDoe_d  = 1'b1;
          state_d   = INTA;
        end
      end
      REQ: begin
        counter_d = cntNext;
        if (bus.f_ack) begin
          fReq_d    = 1'b0;
          waitN_d   = 1'b1;
          busDout_d = bus.f_rdata;
          busDoe_d  = !fWr_q;
          state_d   = HOLD;
        end else if (cntNext == 8'(TIMEOUT_CYCLES)) begin
          fReq_d    = 1'b0;
          waitN_d   = 1'b1;
          busDout_d = 8'hFF;
          busDoe_d  = !fWr_q;
          timeout_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (rdS && wrS && reqStrobeHigh) begin
          busDoe_d  = 1'b0;
          counter_d = 8'd0;
          state_d   = IDLE;
        end
      end
      INTA: begin
        if (iorqS) begin
          busDoe_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset releases wait_n immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= 8'd0;
      busDout_q <= 8'd0;
      busDoe_q  <= 1'b0;
      waitN_q   <= 1'b1;
      fReq_q    <= 1'b0;
      fIo_q     <= 1'b0;
      fWr_q     <= 1'b0;
      fAddr_q   <= 16'd0;
      fWdata_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      busDout_q <= busDout_d;
      busDoe_q  <= busDoe_d;
      waitN_q   <= waitN_d;
      fReq_q    <= fReq_d;
      fIo_q     <= fIo_d;
      fWr_q     <= fWr_d;
      fAddr_q   <= fAddr_d;
      fWdata_q  <= fWdata_d;
      timeout_q <= timeout_d;
    end
  end

  // Interrupt line simply follows the fabric level with one clock of delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) intN_q <= 1'b1;
    else       intN_q <= !bus.irq;
  end

  assign bus.bus_dout = busDout_q;
  assign bus.bus_doe  = busDoe_q;
  assign bus.wait_n   = waitN_q;
  assign bus.int_n    = intN_q;
  assign bus.f_req    = fReq_q;
  assign bus.f_io     = fIo_q;
  assign bus.f_wr     = fWr_q;
  assign bus.f_addr   = fAddr_q;
  assign bus.f_wdata  = fWdata_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed testbench for z80_bus_target: IO write, memory read, INTA, timeout,
// ack on the timeout cycle, aborted strobe, reset mid-cycle and illegal decode.
module tb_z80_bus_target;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  z80_bus_target_if busIf ();

  z80_bus_target #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends even if the design stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drive the four CPU strobes
  task automatic applyStimulus(input logic mreqN, input logic iorqN, input logic rdN, input logic wrN);
    busIf.mreq_n = mreqN;
    busIf.iorq_n = iorqN;
    busIf.rd_n   = rdN;
    busIf.wr_n   = wrN;
  endtask

  // Advance n rising edges and settle 1ns past the last one
  task automatic stepClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle fabric acknowledge with read data
  task automatic pulseAck(input logic [7:0] data);
    busIf.f_ack   = 1'b1;
    busIf.f_rdata = data;
    stepClocks(1);
    busIf.f_ack   = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b1;
    busIf.bus_addr   = 16'h0000;
    busIf.bus_din    = 8'h00;
    busIf.f_ack      = 1'b0;
    busIf.f_rdata    = 8'h00;
    busIf.irq        = 1'b0;
    busIf.irq_vector = 8'h00;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Reset values
    stepClocks(2);
    checkOutput("rst_dout",    {8'h0, busIf.bus_dout}, 16'h0000);
    checkOutput("rst_doe",     {15'h0, busIf.bus_doe}, 16'h0000);
    checkOutput("rst_wait",    {15'h0, busIf.wait_n},  16'h0001);
    checkOutput("rst_int",     {15'h0, busIf.int_n},   16'h0001);
    checkOutput("rst_freq",    {15'h0, busIf.f_req},   16'h0000);
    checkOutput("rst_faddr",   busIf.f_addr,           16'h0000);
    checkOutput("rst_timeout", {15'h0, busIf.timeout}, 16'h0000);
    reset = 1'b0;

    // IO write 00F6 <- 5A, ack after 4 clocks
    busIf.bus_addr = 16'h00F6;
    busIf.bus_din  = 8'h5A;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    stepClocks(2);
    checkOutput("iow_wait_early", {15'h0, busIf.wait_n}, 16'h0001);
    stepClocks(1);
    checkOutput("iow_wait",  {15'h0, busIf.wait_n}, 16'h0000);
    checkOutput("iow_freq",  {15'h0, busIf.f_req},  16'h0001);
    checkOutput("iow_fio",   {15'h0, busIf.f_io},   16'h0001);
    checkOutput("iow_fwr",   {15'h0, busIf.f_wr},   16'h0001);
    checkOutput("iow_faddr", busIf.f_addr,          16'h00F6);
    checkOutput("iow_wdata", {8'h0, busIf.f_wdata}, 16'h005A);
    stepClocks(3);
    checkOutput("iow_wait_held", {15'h0, busIf.wait_n}, 16'h0000);
    pulseAck(8'h00);
    checkOutput("iow_wait_rel", {15'h0, busIf.wait_n}, 16'h0001);
    checkOutput("iow_freq_clr", {15'h0, busIf.f_req},  16'h0000);
    checkOutput("iow_doe",      {15'h0, busIf.bus_doe}, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(3);

    // Memory read 3800 -> C3
    busIf.bus_addr = 16'h3800;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepClocks(3);
    checkOutput("mrd_wait",  {15'h0, busIf.wait_n}, 16'h0000);
    checkOutput("mrd_fio",   {15'h0, busIf.f_io},   16'h0000);
    checkOutput("mrd_fwr",   {15'h0, busIf.f_wr},   16'h0000);
    checkOutput("mrd_faddr", busIf.f_addr,          16'h3800);
    pulseAck(8'hC3);
    checkOutput("mrd_dout", {8'h0, busIf.bus_dout}, 16'h00C3);
    checkOutput("mrd_doe",  {15'h0, busIf.bus_doe}, 16'h0001);
    checkOutput("mrd_wait_rel", {15'h0, busIf.wait_n}, 16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(2);
    checkOutput("mrd_doe_hold", {15'h0, busIf.bus_doe}, 16'h0001);
    stepClocks(1);
    checkOutput("mrd_doe_off", {15'h0, busIf.bus_doe}, 16'h0000);

    // Stray ack in IDLE is ignored
    pulseAck(8'h11);
    checkOutput("idle_ack_dout", {8'h0, busIf.bus_dout}, 16'h00C3);
    checkOutput("idle_ack_freq", {15'h0, busIf.f_req},   16'h0000);

    // Interrupt acknowledge with vector 40
    busIf.irq        = 1'b1;
    busIf.irq_vector = 8'h40;
    stepClocks(1);
    checkOutput("inta_int", {15'h0, busIf.int_n}, 16'h0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    stepClocks(2);
    checkOutput("inta_doe_early", {15'h0, busIf.bus_doe}, 16'h0000);
    stepClocks(1);
    checkOutput("inta_dout", {8'h0, busIf.bus_dout}, 16'h0040);
    checkOutput("inta_doe",  {15'h0, busIf.bus_doe}, 16'h0001);
    checkOutput("inta_wait", {15'h0, busIf.wait_n},  16'h0001);
    checkOutput("inta_freq", {15'h0, busIf.f_req},   16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(2);
    checkOutput("inta_doe_hold", {15'h0, busIf.bus_doe}, 16'h0001);
    stepClocks(1);
    checkOutput("inta_doe_off", {15'h0, busIf.bus_doe}, 16'h0000);
    busIf.irq = 1'b0;
    stepClocks(1);
    checkOutput("irq_clear_int", {15'h0, busIf.int_n}, 16'h0001);

    // Read with no ack: timeout after 255 clocks in REQ
    busIf.bus_addr = 16'h1234;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepClocks(3);
    checkOutput("to_wait_start", {15'h0, busIf.wait_n}, 16'h0000);
    stepClocks(254);
    checkOutput("to_wait_254", {15'h0, busIf.wait_n},  16'h0000);
    checkOutput("to_pulse_254", {15'h0, busIf.timeout}, 16'h0000);
    stepClocks(1);
    checkOutput("to_pulse", {15'h0, busIf.timeout}, 16'h0001);
    checkOutput("to_dout",  {8'h0, busIf.bus_dout}, 16'h00FF);
    checkOutput("to_wait",  {15'h0, busIf.wait_n},  16'h0001);
    checkOutput("to_freq",  {15'h0, busIf.f_req},   16'h0000);
    stepClocks(1);
    checkOutput("to_pulse_end", {15'h0, busIf.timeout}, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(3);

    // Same read, ack arrives on the 255th clock: ack wins
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepClocks(3);
    stepClocks(254);
    pulseAck(8'hA5);
    checkOutput("ack255_timeout", {15'h0, busIf.timeout}, 16'h0000);
    checkOutput("ack255_dout", {8'h0, busIf.bus_dout}, 16'h00A5);
    checkOutput("ack255_wait", {15'h0, busIf.wait_n},  16'h0001);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(3);

    // Strobe dropped while in REQ: HOLD exits one clock after the ack
    busIf.bus_addr = 16'h2000;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepClocks(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(2);
    checkOutput("abort_wait", {15'h0, busIf.wait_n}, 16'h0000);
    pulseAck(8'h3C);
    checkOutput("abort_doe", {15'h0, busIf.bus_doe}, 16'h0001);
    stepClocks(1);
    checkOutput("abort_doe_off", {15'h0, busIf.bus_doe}, 16'h0000);

    // Reset asserted mid-REQ releases everything asynchronously
    busIf.bus_addr = 16'h0100;
    busIf.bus_din  = 8'h77;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    stepClocks(3);
    checkOutput("rstmid_wait_pre", {15'h0, busIf.wait_n}, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_wait", {15'h0, busIf.wait_n},  16'h0001);
    checkOutput("rstmid_freq", {15'h0, busIf.f_req},   16'h0000);
    checkOutput("rstmid_doe",  {15'h0, busIf.bus_doe}, 16'h0000);
    stepClocks(1);
    reset = 1'b0;
    stepClocks(3);
    checkOutput("postrst_wait",  {15'h0, busIf.wait_n}, 16'h0000);
    checkOutput("postrst_faddr", busIf.f_addr,          16'h0100);
    checkOutput("postrst_wdata", {8'h0, busIf.f_wdata}, 16'h0077);
    checkOutput("postrst_fwr",   {15'h0, busIf.f_wr},   16'h0001);
    pulseAck(8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(3);

    // mreq_n and iorq_n both low with rd_n low: ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stepClocks(4);
    checkOutput("both_freq", {15'h0, busIf.f_req},   16'h0000);
    checkOutput("both_wait", {15'h0, busIf.wait_n},  16'h0001);
    checkOutput("both_doe",  {15'h0, busIf.bus_doe}, 16'h0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    stepClocks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
